// File: rtl/intc_arb.sv
// ============================================================================
// Module      : intc_arb
// Description : Interrupt arbiter: eight level-type peripheral sources with
//               programmable 4-bit priorities, plus edge-detected NMI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_arb #(
    parameter int          NSRC    = 8,
    parameter logic [7:0]  NMI_VEC = 8'd11,
    parameter logic [31:0] BASE    = 32'hFFFFFEE0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic              CE_F,
    input  logic              RES_N,
    input  logic              NMI_N,
    input  logic [NSRC-1:0]   IRQ,
    input  logic [8*NSRC-1:0] VEC,
    input  logic [31:0]       IBUS_A,
    input  logic [31:0]       IBUS_DI,
    output logic [31:0]       IBUS_DO,
    input  logic [3:0]        IBUS_BA,
    input  logic              IBUS_WE,
    input  logic              IBUS_REQ,
    output logic              IBUS_BUSY,
    output logic              IBUS_ACT,
    output logic              INT_REQ,
    output logic              INT_NMI,
    output logic [3:0]        INT_LVL,
    output logic [7:0]        INT_VEC,
    input  logic              INT_ACK
);

    localparam logic [3:0] c_NMI_LVL = 4'hF;

    logic [1:0]  r_nmi_sync;
    logic        r_nmi_prev;
    logic        r_nmi_pend;
    logic        r_nmie;
    logic [15:0] r_ipra;
    logic [15:0] r_iprb;
    logic        r_int_req;
    logic        r_int_nmi;
    logic [3:0]  r_int_lvl;
    logic [7:0]  r_int_vec;
    logic [31:0] r_ibus_do;

    logic        w_sel;
    logic        w_sel0;
    logic        w_sel1;
    logic        w_wr0;
    logic        w_wr1;
    logic [31:0] w_rdata;
    logic        w_nmil;
    logic        w_nmi_edge;
    logic        w_nmi_pend_nxt;
    logic [31:0] w_ipr_all;
    logic [3:0]  w_lvl [NSRC];
    logic        w_win_req;
    logic [3:0]  w_win_lvl;
    logic [7:0]  w_win_vec;
    logic        w_unused;

    // Register block spans two words; low address bits are don't-care.
    assign w_sel     = IBUS_REQ && (IBUS_A[31:3] == BASE[31:3]);
    assign w_sel0    = w_sel && !IBUS_A[2];
    assign w_sel1    = w_sel &&  IBUS_A[2];
    assign w_wr0     = w_sel0 && IBUS_WE;
    assign w_wr1     = w_sel1 && IBUS_WE;
    assign IBUS_ACT  = w_sel;
    assign IBUS_BUSY = 1'b0;
    assign w_unused  = &{1'b0, IBUS_A[1:0]};

    assign w_rdata = w_sel0 ? {w_nmil, 6'b0, r_nmie, 8'b0, r_ipra} :
                     w_sel1 ? {r_iprb, 16'b0} : 32'b0;

    // Edges come from the synchronised level history only, so toggling NMIE
    // never fabricates one.
    assign w_nmil         = r_nmi_sync[1];
    assign w_nmi_edge     = r_nmie ? (w_nmil & ~r_nmi_prev) : (~w_nmil & r_nmi_prev);
    assign w_nmi_pend_nxt = w_nmi_edge | (r_nmi_pend & ~(INT_ACK & r_int_nmi));

    assign w_ipr_all = {r_ipra, r_iprb};

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_lvl
            assign w_lvl[gi] = w_ipr_all[31-4*gi -: 4];
        end
    endgenerate

    // Strict greater-than keeps the lower index on ties; level 0 never wins.
    always_comb begin
        w_win_req = 1'b0;
        w_win_lvl = 4'd0;
        w_win_vec = 8'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (IRQ[i] && (w_lvl[i] > w_win_lvl)) begin
                w_win_req = 1'b1;
                w_win_lvl = w_lvl[i];
                w_win_vec = VEC[8*i +: 8];
            end
        end
    end

    // Synchroniser keeps running through soft reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_nmi_sync <= 2'b11;
            r_nmi_prev <= 1'b1;
        end else if (CE_R) begin
            r_nmi_sync <= {r_nmi_sync[0], NMI_N};
            r_nmi_prev <= r_nmi_sync[1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_nmi_pend <= 1'b0;
            r_nmie     <= 1'b0;
            r_ipra     <= 16'h0000;
            r_iprb     <= 16'h0000;
        end else if (CE_R) begin
            if (!RES_N) begin
                r_nmi_pend <= 1'b0;
                r_nmie     <= 1'b0;
                r_ipra     <= 16'h0000;
                r_iprb     <= 16'h0000;
            end else begin
                r_nmi_pend <= w_nmi_pend_nxt;
                if (w_wr0) begin
                    if (IBUS_BA[3]) r_nmie       <= IBUS_DI[24];
                    if (IBUS_BA[1]) r_ipra[15:8] <= IBUS_DI[15:8];
                    if (IBUS_BA[0]) r_ipra[7:0]  <= IBUS_DI[7:0];
                end
                if (w_wr1) begin
                    if (IBUS_BA[3]) r_iprb[15:8] <= IBUS_DI[31:24];
                    if (IBUS_BA[2]) r_iprb[7:0]  <= IBUS_DI[23:16];
                end
            end
        end
    end

    // Outputs follow the next pending state so an acknowledged NMI drops
    // on the same edge that clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_int_req <= 1'b0;
            r_int_nmi <= 1'b0;
            r_int_lvl <= 4'd0;
            r_int_vec <= 8'd0;
        end else if (CE_R) begin
            if (!RES_N) begin
                r_int_req <= 1'b0;
                r_int_nmi <= 1'b0;
                r_int_lvl <= 4'd0;
                r_int_vec <= 8'd0;
            end else if (w_nmi_pend_nxt) begin
                r_int_req <= 1'b1;
                r_int_nmi <= 1'b1;
                r_int_lvl <= c_NMI_LVL;
                r_int_vec <= NMI_VEC;
            end else begin
                r_int_req <= w_win_req;
                r_int_nmi <= 1'b0;
                r_int_lvl <= w_win_lvl;
                r_int_vec <= w_win_vec;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ibus_do <= 32'b0;
        end else if (CE_R && !RES_N) begin
            r_ibus_do <= 32'b0;
        end else if (CE_F) begin
            r_ibus_do <= w_rdata;
        end
    end

    assign IBUS_DO = r_ibus_do;
    assign INT_REQ = r_int_req;
    assign INT_NMI = r_int_nmi;
    assign INT_LVL = r_int_lvl;
    assign INT_VEC = r_int_vec;

endmodule

`default_nettype wire

// File: tb/tb_intc_arb.sv
// ============================================================================
// Module      : tb_intc_arb
// Description : Directed self-checking bench for intc_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intc_arb;

    localparam logic [31:0] c_BASE = 32'hFFFFFEE0;

    logic        CLK;
    logic        RST;
    logic        CE_R;
    logic        CE_F;
    logic        RES_N;
    logic        NMI_N;
    logic [7:0]  IRQ;
    logic [63:0] VEC;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;
    logic        INT_REQ;
    logic        INT_NMI;
    logic [3:0]  INT_LVL;
    logic [7:0]  INT_VEC;
    logic        INT_ACK;

    int n_tests = 0;
    int n_fail  = 0;

    intc_arb #(
        .NSRC    (8),
        .NMI_VEC (8'd11),
        .BASE    (c_BASE)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE_R      (CE_R),
        .CE_F      (CE_F),
        .RES_N     (RES_N),
        .NMI_N     (NMI_N),
        .IRQ       (IRQ),
        .VEC       (VEC),
        .IBUS_A    (IBUS_A),
        .IBUS_DI   (IBUS_DI),
        .IBUS_DO   (IBUS_DO),
        .IBUS_BA   (IBUS_BA),
        .IBUS_WE   (IBUS_WE),
        .IBUS_REQ  (IBUS_REQ),
        .IBUS_BUSY (IBUS_BUSY),
        .IBUS_ACT  (IBUS_ACT),
        .INT_REQ   (INT_REQ),
        .INT_NMI   (INT_NMI),
        .INT_LVL   (INT_LVL),
        .INT_VEC   (INT_VEC),
        .INT_ACK   (INT_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ibus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ba);
        IBUS_A   = addr;
        IBUS_DI  = data;
        IBUS_BA  = ba;
        IBUS_WE  = 1'b1;
        IBUS_REQ = 1'b1;
        tick();
        IBUS_WE  = 1'b0;
        IBUS_REQ = 1'b0;
        IBUS_BA  = 4'b0000;
    endtask

    task automatic ibus_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        IBUS_A   = addr;
        IBUS_WE  = 1'b0;
        IBUS_REQ = 1'b1;
        #1;
        check({tag, "_act"}, 32'(IBUS_ACT), 32'h1);
        tick();
        check(tag, IBUS_DO, exp);
        IBUS_REQ = 1'b0;
    endtask

    task automatic check_int(input string tag, input logic req, input logic nmi,
                             input logic [3:0] lvl, input logic [7:0] vec);
        check({tag, "_req"}, 32'(INT_REQ), 32'(req));
        check({tag, "_nmi"}, 32'(INT_NMI), 32'(nmi));
        check({tag, "_lvl"}, 32'(INT_LVL), 32'(lvl));
        check({tag, "_vec"}, 32'(INT_VEC), 32'(vec));
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        CE_R     = 1'b1;
        CE_F     = 1'b1;
        RES_N    = 1'b1;
        NMI_N    = 1'b1;
        IRQ      = 8'h00;
        VEC      = 64'h0000_4400_005A_2270;
        IBUS_A   = 32'h0;
        IBUS_DI  = 32'h0;
        IBUS_BA  = 4'b0000;
        IBUS_WE  = 1'b0;
        IBUS_REQ = 1'b0;
        INT_ACK  = 1'b0;

        tick(2);
        check_int("rst", 1'b0, 1'b0, 4'h0, 8'h00);
        check("rst_do", IBUS_DO, 32'h0);
        check("rst_busy", 32'(IBUS_BUSY), 32'h0);
        RST = 1'b0;
        tick();
        ibus_rd("rd_rst", c_BASE, 32'h8000_0000);

        // Single source, one CE_R latency in and out
        ibus_wr(c_BASE, 32'h0000_5000, 4'b0011);
        IRQ = 8'h01;
        #1;
        check("t1_lat", 32'(INT_REQ), 32'h0);
        tick();
        check_int("t1_on", 1'b1, 1'b0, 4'h5, 8'h70);
        IRQ = 8'h00;
        tick();
        check_int("t1_off", 1'b0, 1'b0, 4'h0, 8'h00);

        // Highest level wins; then equal levels resolve to lower index
        ibus_wr(c_BASE, 32'h0000_0300, 4'b0011);
        ibus_wr(c_BASE + 32'd4, 32'h0900_0000, 4'b1100);
        IRQ = 8'h22;
        tick();
        check_int("t2_hi", 1'b1, 1'b0, 4'h9, 8'h44);
        ibus_wr(c_BASE + 32'd4, 32'h0300_0000, 4'b1100);
        check_int("t2_old", 1'b1, 1'b0, 4'h9, 8'h44);
        tick();
        check_int("t2_tie", 1'b1, 1'b0, 4'h3, 8'h22);

        CE_R = 1'b0;
        IRQ  = 8'h00;
        tick();
        check("ce_hold", 32'(INT_REQ), 32'h1);
        CE_R = 1'b1;
        tick();
        check("ce_go", 32'(INT_REQ), 32'h0);

        // Masked level, byte-lane write, readback
        IRQ = 8'h01;
        tick();
        check("t5_mask", 32'(INT_REQ), 32'h0);
        ibus_wr(c_BASE, 32'hFFFF_FFAB, 4'b0001);
        ibus_rd("t5_rd", c_BASE, 32'h8000_03AB);
        tick();
        check("t5_unsel", IBUS_DO, 32'h0);

        // Falling-edge NMI overrides a level-15 source
        ibus_wr(c_BASE, 32'h0000_03F0, 4'b0011);
        IRQ = 8'h04;
        tick();
        check_int("t3_src", 1'b1, 1'b0, 4'hF, 8'h5A);
        NMI_N = 1'b0;
        tick(2);
        check("t3_lat", 32'(INT_NMI), 32'h0);
        tick();
        check_int("t3_nmi", 1'b1, 1'b1, 4'hF, 8'h0B);
        ibus_rd("t3_nmil", c_BASE, 32'h0000_03F0);
        ack();
        check_int("t3_ack", 1'b1, 1'b0, 4'hF, 8'h5A);

        // Rising edge ignored when NMIE=0; new edge on the ACK cycle survives
        NMI_N = 1'b1;
        tick(3);
        check("t4_rise", 32'(INT_NMI), 32'h0);
        NMI_N = 1'b0;
        tick(3);
        check("t4_pend", 32'(INT_NMI), 32'h1);
        NMI_N = 1'b1;
        tick(3);
        check("t4_hold", 32'(INT_NMI), 32'h1);
        NMI_N = 1'b0;
        tick(2);
        ack();
        check("t4_ackedge", 32'(INT_NMI), 32'h1);
        ack();
        check_int("t4_clr", 1'b1, 1'b0, 4'hF, 8'h5A);

        // Switching to rising-edge mode with the pin low makes no edge
        ibus_wr(c_BASE, 32'h0100_0000, 4'b1000);
        tick(3);
        check("nmie_noedge", 32'(INT_NMI), 32'h0);
        ibus_rd("nmie_rd", c_BASE, 32'h0100_03F0);
        NMI_N = 1'b1;
        tick(3);
        check("nmie_rise", 32'(INT_NMI), 32'h1);
        ack();
        check("nmie_ack", 32'(INT_NMI), 32'h0);

        // Asynchronous reset mid-request, then soft reset
        RST = 1'b1;
        #1;
        check_int("t6_rst", 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        RST = 1'b0;
        ibus_rd("t6_rd", c_BASE, 32'h8000_0000);
        ibus_wr(c_BASE, 32'h0000_00F0, 4'b0011);
        tick();
        check_int("t6_re", 1'b1, 1'b0, 4'hF, 8'h5A);
        RES_N = 1'b0;
        tick();
        check("t6_resn", 32'(INT_REQ), 32'h0);
        RES_N = 1'b1;
        tick();
        check("t6_ipr", 32'(INT_REQ), 32'h0);
        ibus_rd("t6_rd2", c_BASE, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
